// File: rtl/fpga_bitserial_pkg.sv
// Shared types and limits for the bit-serial adder.
package fpga_bitserial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/fpga_carry_logic.sv
// Fabric carry cell: majority of the two operand bits and the incoming carry.
module fpga_carry_logic (
   input  logic i0_i,
   input  logic i1_i,
   input  logic fcin_i,
   output logic fcout_o
);

   assign fcout_o = (i0_i & i1_i) | (i0_i & fcin_i) | (i1_i & fcin_i);

endmodule

// File: rtl/fpga_bitserial_adder.sv
// LSB-first bit-serial adder built around one carry cell and a carry flop.
// Define FPGA_BITSERIAL_SUB_EN to add the sub_i port (a - b via ~b and carry-in 1).
//
// state | meaning
// IDLE  | waiting for start_i; operands captured on accept
// RUN   | one sum bit per cycle, WIDTH cycles
// DONE  | one-cycle done_o pulse; result registers valid
module fpga_bitserial_adder
   import fpga_bitserial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
`ifdef FPGA_BITSERIAL_SUB_EN
   input  logic             sub_i,
`endif
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int CNT_W = $clog2(WIDTH);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("fpga_bitserial_adder: WIDTH out of range");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
   logic             carry_q, cout_q;
   logic             accept, last, bit_s, fcout;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

`ifdef FPGA_BITSERIAL_SUB_EN
   assign b_load = sub_i ? ~b_i : b_i;
   assign c_load = sub_i ? 1'b1 : cin_i;
`else
   assign b_load = b_i;
   assign c_load = cin_i;
`endif

   fpga_carry_logic u_carry (
      .i0_i    (a_q[0]),
      .i1_i    (b_q[0]),
      .fcin_i  (carry_q),
      .fcout_o (fcout)
   );

   assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
   assign last  = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy_o = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result registers only update on the final bit, so sum_o/cout_o never show partial sums.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         cnt_q   <= '0;
         a_q     <= a_i;
         b_q     <= b_load;
         acc_q   <= '0;
         carry_q <= c_load;
      end else if (state_q == RUN) begin
         cnt_q   <= cnt_q + 1'b1;
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         acc_q   <= {bit_s, acc_q[WIDTH-1:1]};
         carry_q <= fcout;
         if (last) begin
            sum_q  <= {bit_s, acc_q[WIDTH-1:1]};
            cout_q <= fcout;
         end
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;

endmodule

// File: tb/tb_fpga_bitserial_adder.sv
// Self-checking bench for fpga_bitserial_adder (WIDTH=8), directed plus random operands.
module tb_fpga_bitserial_adder;

   localparam int WIDTH = 8;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             start_i = 1'b0;
   logic             sub_i = 1'b0;
   logic [WIDTH-1:0] a_i = '0;
   logic [WIDTH-1:0] b_i = '0;
   logic             cin_i = 1'b0;
   logic             busy_o, done_o, cout_o;
   logic [WIDTH-1:0] sum_o;

   int tests = 0;
   int fails = 0;

   fpga_bitserial_adder #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (start_i),
`ifdef FPGA_BITSERIAL_SUB_EN
      .sub_i   (sub_i),
`endif
      .a_i     (a_i),
      .b_i     (b_i),
      .cin_i   (cin_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .sum_o   (sum_o),
      .cout_o  (cout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic c, input logic s);
      if (s) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
   endfunction

   // mode 0: plain; mode 1: pulse start with a=FF mid-run; mode 2: keep start high afterwards
   task automatic do_txn(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s, input int mode);
      logic [WIDTH:0]   exp;
      logic [WIDTH-1:0] prev;
      int               lat, busy_cnt;
      bit               stable;
      exp  = model(a, b, c, s);
      prev = sum_o;
      a_i = a; b_i = b; cin_i = c; sub_i = s; start_i = 1'b1;
      step();
      if (mode != 2) start_i = 1'b0;
      a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); cin_i = 1'($urandom);
      lat = 0; busy_cnt = 0; stable = 1'b1;
      while (!done_o && lat < 20) begin
         if (busy_o) busy_cnt++;
         if (sum_o !== prev) stable = 1'b0;
         if (mode == 1 && lat == 3) begin
            start_i = 1'b1;
            a_i = 8'hFF;
         end else if (mode != 2) begin
            start_i = 1'b0;
         end
         step();
         lat++;
      end
      if (mode != 2) start_i = 1'b0;
      check({tag, "_done"}, 32'(done_o), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
      check({tag, "_sum"}, 32'(sum_o), 32'(exp[WIDTH-1:0]));
      check({tag, "_cout"}, 32'(cout_o), 32'(exp[WIDTH]));
      check({tag, "_stable"}, 32'(stable), 32'd1);
      if (busy_o) busy_cnt++;
      prev = sum_o;
      step();
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
      check({tag, "_done_single"}, 32'(done_o), 32'd0);
      check({tag, "_idle"}, 32'(busy_o), 32'd0);
      check({tag, "_hold"}, 32'(sum_o), 32'(prev));
   endtask

   initial begin
      bit             no_done;
      logic [WIDTH-1:0] ra, rb;
      logic           rc, rs;

      rst_ni = 1'b0;
      step();
      step();
      check("rst_sum", 32'(sum_o), 32'd0);
      check("rst_cout", 32'(cout_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      rst_ni = 1'b1;
      step();
      check("idle_no_start", 32'(busy_o), 32'd0);

      do_txn("add_05_03", 8'h05, 8'h03, 1'b0, 1'b0, 0);
      do_txn("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
      do_txn("add_00_00_c1", 8'h00, 8'h00, 1'b1, 1'b0, 0);
      do_txn("ignore_start", 8'h10, 8'h20, 1'b0, 1'b0, 1);

      // Reset partway through RUN discards the operation.
      a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      step(); step(); step();
      rst_ni = 1'b0;
      step();
      check("midrst_sum", 32'(sum_o), 32'd0);
      check("midrst_cout", 32'(cout_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_done", 32'(done_o), 32'd0);
      rst_ni = 1'b1;
      no_done = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done_o || busy_o) no_done = 1'b0;
      end
      check("midrst_quiet", 32'(no_done), 32'd1);
      do_txn("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 0);

      // Start held high: each accept lands on the edge after the DONE->IDLE edge.
      for (int i = 0; i < 4; i++) begin
         ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
         do_txn("b2b", ra, rb, rc, 1'b0, 2);
      end
      start_i = 1'b0;
      step();

`ifdef FPGA_BITSERIAL_SUB_EN
      do_txn("sub_05_03", 8'h05, 8'h03, 1'b0, 1'b1, 0);
      do_txn("sub_03_05", 8'h03, 8'h05, 1'b1, 1'b1, 0);
`endif

      for (int i = 0; i < 20; i++) begin
         ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
`ifdef FPGA_BITSERIAL_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         do_txn("rand", ra, rb, rc, rs, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
